// File: rtl/elevator_nfloor_ctrl.sv
// N-floor elevator controller: latches per-floor calls and sweeps in the last travel
// direction before reversing. It holds the door open on a stop, on a door-hold and on re-calls.
module elevator_nfloor_ctrl #(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    localparam int FLOOR_W      = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] floor_onehot,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TRAVEL_LOAD = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DOOR_LOAD   = DCNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      floor_nxt;
    logic [FLOOR_W-1:0]      floor_up;
    logic [FLOOR_W-1:0]      floor_dn;
    logic [NUM_FLOORS-1:0]   pend_or;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   pending_nxt;
    logic                    dir_up, dir_nxt;
    logic [TCNT_W-1:0]       tcnt, tcnt_nxt;
    logic [DCNT_W-1:0]       dcnt, dcnt_nxt;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i > int'(f)) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((i < int'(f)) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Arrival decisions look at calls raised this very cycle too, so a call made
    // exactly as the car reaches a floor still stops it there.
    always_comb begin
        state_nxt  = state;
        floor_nxt  = current_floor;
        dir_nxt    = dir_up;
        tcnt_nxt   = tcnt;
        dcnt_nxt   = dcnt;
        clear_mask = '0;
        pend_or    = pending | call_req;
        floor_up   = current_floor + FLOOR_W'(1);
        floor_dn   = current_floor - FLOOR_W'(1);

        case (state)
            IDLE: begin
                if (pending[current_floor]) begin
                    state_nxt                 = DOOR_OPEN;
                    dcnt_nxt                  = DOOR_LOAD;
                    clear_mask[current_floor] = 1'b1;
                end else if (any_above(pending, current_floor) &&
                             (dir_up || !any_below(pending, current_floor))) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = 1'b1;
                    tcnt_nxt  = TRAVEL_LOAD;
                end else if (any_below(pending, current_floor)) begin
                    state_nxt = MOVE_DOWN;
                    dir_nxt   = 1'b0;
                    tcnt_nxt  = TRAVEL_LOAD;
                end
            end
            MOVE_UP: begin
                if (tcnt != '0) begin
                    tcnt_nxt = tcnt - TCNT_W'(1);
                end else begin
                    floor_nxt = floor_up;
                    tcnt_nxt  = TRAVEL_LOAD;
                    if (pend_or[floor_up]) begin
                        state_nxt            = DOOR_OPEN;
                        dcnt_nxt             = DOOR_LOAD;
                        clear_mask[floor_up] = 1'b1;
                    end else if (!any_above(pend_or, floor_up)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (tcnt != '0) begin
                    tcnt_nxt = tcnt - TCNT_W'(1);
                end else begin
                    floor_nxt = floor_dn;
                    tcnt_nxt  = TRAVEL_LOAD;
                    if (pend_or[floor_dn]) begin
                        state_nxt            = DOOR_OPEN;
                        dcnt_nxt             = DOOR_LOAD;
                        clear_mask[floor_dn] = 1'b1;
                    end else if (!any_below(pend_or, floor_dn)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                clear_mask[current_floor] = 1'b1;
                if (call_req[current_floor] || hold) begin
                    dcnt_nxt = DOOR_LOAD;
                end else if (dcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    dcnt_nxt = dcnt - DCNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        pending_nxt = pend_or & ~clear_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            tcnt          <= TRAVEL_LOAD;
            dcnt          <= DOOR_LOAD;
        end else begin
            current_floor <= floor_nxt;
            pending       <= pending_nxt;
            dir_up        <= dir_nxt;
            tcnt          <= tcnt_nxt;
            dcnt          <= dcnt_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_onehot[i] = (int'(current_floor) == i);
        end
    end

    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_nfloor_ctrl.sv
// Scoreboarded bench for elevator_nfloor_ctrl: each expected door stop (floor, open length)
// is queued when its call is driven and is matched when the door closes.
module tb_elevator_nfloor_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] call_req;
    logic       hold;
    logic [1:0] current_floor;
    logic [3:0] floor_onehot;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [3:0] pending;

    typedef struct {
        int floor;
        int len;
    } door_exp_t;

    door_exp_t sb[$];
    int        total = 0;
    int        bad = 0;
    bit        mon_prev = 1'b0;
    int        mon_len = 0;

    elevator_nfloor_ctrl #(
        .NUM_FLOORS   (4),
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .hold         (hold),
        .current_floor(current_floor),
        .floor_onehot (floor_onehot),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .door_open    (door_open),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard side: each closed door episode must match the oldest queued stop.
    always @(negedge clk) begin
        if (reset) begin
            mon_prev = 1'b0;
            mon_len  = 0;
        end else begin
            total++;
            if (floor_onehot !== (4'b0001 << current_floor) || (moving_up && moving_down)) begin
                bad++;
                $display("[TB] FAIL invariant: onehot=%b floor=%0d up=%b down=%b",
                         floor_onehot, current_floor, moving_up, moving_down);
            end
            if (door_open) begin
                mon_len++;
                mon_prev = 1'b1;
            end else if (mon_prev) begin
                door_exp_t e;
                mon_prev = 1'b0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL door_unexpected: floor=%0d len=%0d required no stop",
                             current_floor, mon_len);
                end else begin
                    e = sb.pop_front();
                    if (int'(current_floor) !== e.floor || mon_len !== e.len) begin
                        bad++;
                        $display("[TB] FAIL door_stop: floor=%0d len=%0d required floor=%0d len=%0d",
                                 current_floor, mon_len, e.floor, e.len);
                    end
                end
                mon_len = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        call_req = '0;
        hold     = 1'b0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_call(input logic [3:0] v);
        call_req = v;
        step();
        call_req = '0;
    endtask

    task automatic wait_drain(input int budget, output int left);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        left = sb.size();
        sb.delete();
    endtask

    task automatic wait_door(input int budget, output bit seen);
        int n = 0;
        while (!door_open && n < budget) begin
            step();
            n++;
        end
        seen = door_open;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        call_req = 4'b0100;
        hold     = 1'b0;
        #1;
        total++;
        if (current_floor !== 2'd0 || floor_onehot !== 4'b0001 || pending !== 4'b0000 ||
            moving_up !== 1'b0 || moving_down !== 1'b0 || door_open !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: floor=%0d onehot=%b pend=%b up=%b dn=%b door=%b",
                     current_floor, floor_onehot, pending, moving_up, moving_down, door_open);
        end
        step();
        total++;
        if (pending !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_blocks_calls: pend=%b required 0000", pending);
        end
        reset = 1'b0;
        step();
        total++;
        if (pending !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL first_sample: pend=%b required 0100", pending);
        end
        do_reset();
    endtask

    task automatic test_same_floor();
        int left;
        sb.push_back('{0, 4});
        pulse_call(4'b0001);
        step();
        total++;
        if (door_open !== 1'b1 || pending !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL same_floor_open: door=%b pend=%b required 1 0000", door_open, pending);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (moving_up !== 1'b0 || moving_down !== 1'b0 || current_floor !== 2'd0) begin
                bad++;
                $display("[TB] FAIL same_floor_still: up=%b dn=%b floor=%0d required 0 0 0",
                         moving_up, moving_down, current_floor);
            end
            step();
        end
        wait_drain(50, left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("[TB] FAIL same_floor_timeout: left=%0d required 0", left);
        end
    endtask

    task automatic test_basic();
        int left;
        sb.push_back('{2, 4});
        pulse_call(4'b0100);
        total++;
        if (pending !== 4'b0100 || moving_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_latch: pend=%b up=%b required 0100 0", pending, moving_up);
        end
        step();
        total++;
        if (moving_up !== 1'b1 || current_floor !== 2'd0) begin
            bad++;
            $display("[TB] FAIL basic_start: up=%b floor=%0d required 1 0", moving_up, current_floor);
        end
        repeat (7) step();
        total++;
        if (current_floor !== 2'd0) begin
            bad++;
            $display("[TB] FAIL basic_early: floor=%0d required 0", current_floor);
        end
        step();
        total++;
        if (current_floor !== 2'd1 || moving_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_floor1: floor=%0d up=%b required 1 1", current_floor, moving_up);
        end
        repeat (8) step();
        total++;
        if (current_floor !== 2'd2 || door_open !== 1'b1 || pending !== 4'b0000 || moving_up !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_arrive: floor=%0d door=%b pend=%b up=%b required 2 1 0000 0",
                     current_floor, door_open, pending, moving_up);
        end
        repeat (4) step();
        total++;
        if (door_open !== 1'b0 || moving_up !== 1'b0 || moving_down !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_idle: door=%b up=%b dn=%b required 0 0 0",
                     door_open, moving_up, moving_down);
        end
        wait_drain(20, left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("[TB] FAIL basic_timeout: left=%0d required 0", left);
        end
    endtask

    task automatic test_sweep();
        int left;
        sb.push_back('{3, 4});
        sb.push_back('{0, 4});
        pulse_call(4'b1001);
        total++;
        if (pending !== 4'b1001) begin
            bad++;
            $display("[TB] FAIL sweep_latch: pend=%b required 1001", pending);
        end
        step();
        total++;
        if (moving_up !== 1'b1 || moving_down !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sweep_dir: up=%b dn=%b required 1 0", moving_up, moving_down);
        end
        wait_drain(200, left);
        total++;
        if (left !== 0 || current_floor !== 2'd0) begin
            bad++;
            $display("[TB] FAIL sweep_done: left=%0d floor=%0d required 0 0", left, current_floor);
        end
    endtask

    task automatic test_hold();
        int left;
        bit seen;
        sb.push_back('{0, 14});
        pulse_call(4'b0001);
        wait_door(10, seen);
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_door_seen: door=%b required 1", seen);
        end
        hold = 1'b1;
        repeat (10) step();
        hold = 1'b0;
        total++;
        if (door_open !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_kept_open: door=%b required 1", door_open);
        end
        wait_drain(50, left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("[TB] FAIL hold_timeout: left=%0d required 0", left);
        end
    endtask

    task automatic test_hold_travel();
        int left;
        sb.push_back('{3, 4});
        hold = 1'b1;
        pulse_call(4'b1000);
        step();
        total++;
        if (moving_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_travel_start: up=%b required 1", moving_up);
        end
        repeat (7) step();
        total++;
        if (current_floor !== 2'd0) begin
            bad++;
            $display("[TB] FAIL hold_travel_early: floor=%0d required 0", current_floor);
        end
        step();
        total++;
        if (current_floor !== 2'd1 || moving_up !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_travel_floor1: floor=%0d up=%b required 1 1", current_floor, moving_up);
        end
        hold = 1'b0;
        wait_drain(100, left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("[TB] FAIL hold_travel_timeout: left=%0d required 0", left);
        end
    endtask

    task automatic test_mid_call();
        int left;
        do_reset();
        sb.push_back('{1, 4});
        sb.push_back('{3, 4});
        pulse_call(4'b1000);
        repeat (4) step();
        pulse_call(4'b0010);
        total++;
        if (pending !== 4'b1010 || moving_up !== 1'b1 || current_floor !== 2'd0) begin
            bad++;
            $display("[TB] FAIL mid_call_latch: pend=%b up=%b floor=%0d required 1010 1 0",
                     pending, moving_up, current_floor);
        end
        wait_drain(200, left);
        total++;
        if (left !== 0) begin
            bad++;
            $display("[TB] FAIL mid_call_timeout: left=%0d required 0", left);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        pulse_call(4'b1000);
        while (current_floor !== 2'd1 && n < 50) begin
            step();
            n++;
        end
        total++;
        if (current_floor !== 2'd1) begin
            bad++;
            $display("[TB] FAIL reset_mid_reach: floor=%0d required 1", current_floor);
        end
        repeat (3) step();
        pulse_call(4'b0100);
        sb.delete();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (current_floor !== 2'd0 || floor_onehot !== 4'b0001 || pending !== 4'b0000 ||
            moving_up !== 1'b0 || moving_down !== 1'b0 || door_open !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_values: floor=%0d onehot=%b pend=%b up=%b dn=%b door=%b",
                     current_floor, floor_onehot, pending, moving_up, moving_down, door_open);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (moving_up !== 1'b0 || pending !== 4'b0000 || current_floor !== 2'd0) begin
                bad++;
                $display("[TB] FAIL reset_mid_after: up=%b pend=%b floor=%0d required 0 0000 0",
                         moving_up, pending, current_floor);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        call_req = '0;
        hold     = 1'b0;
        test_reset();
        test_same_floor();
        test_basic();
        test_sweep();
        test_hold();
        test_hold_travel();
        test_mid_call();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
